// File: rtl/jstk_pkg.sv
// Shared types and frame layout for the PmodJSTK poll scheduler.
// Frame fields are given by the LSB of each byte-aligned slice.
package jstk_pkg;

  typedef enum logic [1:0] {IDLE, REQ, BUSY, LATCH} jstk_state_e;

  localparam logic [7:0] JSTK_CMD_BASE = 8'h80;

  localparam int X_LO = 32;
  localparam int X_HI = 24;
  localparam int Y_LO = 16;
  localparam int Y_HI = 8;
  localparam int BTN  = 0;

  // 10-bit position: two high bits from the HI byte, low byte from the LO byte.
  function automatic logic [9:0] pos_field(input logic [39:0] f, input int lo, input int hi);
    return {f[hi +: 2], f[lo +: 8]};
  endfunction

endpackage

// File: rtl/jstk_poll_timer.sv
// Free-running poll divider plus the coalescing request flag.
// A request arriving on the same edge the FSM consumes the flag is kept.
module jstk_poll_timer #(
  parameter int POLL_DIV = 100000
) (
  input  logic CLK,
  input  logic RST,
  input  logic enable,
  input  logic poll_now,
  input  logic pend_clr,
  output logic pending
);

  localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  logic [TW-1:0] cnt;
  logic          wrap;
  logic          tick;

  assign wrap = (cnt == TW'(POLL_DIV - 1));
  assign tick = wrap & enable;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt     <= wrap ? '0 : cnt + TW'(1);
      pending <= (pending & ~pend_clr) | tick | poll_now;
    end
  end

endmodule

// File: rtl/jstk_poll_sched.sv
// Poll scheduler FSM: request/handshake with the SPI controller, frame decode, hang abort.
//   state | meaning
//   IDLE  | waiting for a pending poll while ss_in is high
//   REQ   | snd_rec asserted, waiting for ss_in low
//   BUSY  | transfer in progress, waiting for ss_in high
//   LATCH | one cycle, new sample presented with sample_valid
module jstk_poll_sched
  import jstk_pkg::*;
#(
  parameter int POLL_DIV = 100000,
  parameter int TIMEOUT  = 4095
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enable,
  input  logic        poll_now,
  input  logic [1:0]  led,
  input  logic        err_clr,
  input  logic        ss_in,
  input  logic [39:0] dout_in,
  output logic        snd_rec,
  output logic [7:0]  din,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic [2:0]  btn,
  output logic        sample_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  jstk_state_e   state;
  logic [CW-1:0] tcnt;
  logic          pending;
  logic          pend_clr;

  assign pend_clr = (state == IDLE) && pending && ss_in;

  jstk_poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .poll_now (poll_now),
    .pend_clr (pend_clr),
    .pending  (pending)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      tcnt         <= '0;
      snd_rec      <= 1'b0;
      din          <= JSTK_CMD_BASE;
      x_pos        <= '0;
      y_pos        <= '0;
      btn          <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pending && ss_in) begin
            state   <= REQ;
            snd_rec <= 1'b1;
            busy    <= 1'b1;
            din     <= JSTK_CMD_BASE | {6'b0, led};
            tcnt    <= CW'(TIMEOUT - 1);
          end
        end
        REQ, BUSY: begin
          // Abort takes priority over a same-cycle handshake edge; set beats err_clr.
          if (tcnt == '0) begin
            state       <= IDLE;
            snd_rec     <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt - CW'(1);
            if (state == REQ && !ss_in) begin
              state <= BUSY;
            end else if (state == BUSY && ss_in) begin
              state        <= LATCH;
              snd_rec      <= 1'b0;
              sample_valid <= 1'b1;
              x_pos        <= pos_field(dout_in, X_LO, X_HI);
              y_pos        <= pos_field(dout_in, Y_LO, Y_HI);
              btn          <= dout_in[BTN +: 3];
            end
          end
        end
        LATCH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Self-checking bench for jstk_poll_sched: vector table, random transactions
// against a byte-level decode model, and hand-timed period/coalesce/timeout/reset sequences.
module tb_jstk_poll_sched;

  logic        CLK = 1'b0;
  logic        RST, enable, poll_now, err_clr, ss_in;
  logic [1:0]  led;
  logic [39:0] dout_in;
  logic        snd_rec, sample_valid, busy, timeout_err;
  logic [7:0]  din;
  logic [9:0]  x_pos, y_pos;
  logic [2:0]  btn;

  jstk_poll_sched #(.POLL_DIV(100), .TIMEOUT(50)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .poll_now(poll_now), .led(led),
    .err_clr(err_clr), .ss_in(ss_in), .dout_in(dout_in), .snd_rec(snd_rec),
    .din(din), .x_pos(x_pos), .y_pos(y_pos), .btn(btn),
    .sample_valid(sample_valid), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  logic [9:0] last_x, last_y;
  logic [2:0] last_b;

  typedef struct {
    logic [39:0] fr;
    logic [1:0]  ld;
    logic [1:0]  ld_busy;
    int          lo;
    int          hi;
    logic [9:0]  ex;
    logic [9:0]  ey;
    logic [2:0]  eb;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: split the frame into five bytes, first byte transmitted first.
  task automatic ref_decode(input logic [39:0] f, output logic [9:0] x, output logic [9:0] y,
                            output logic [2:0] b);
    int by[5];
    for (int i = 0; i < 5; i++) by[i] = int'((f >> (8 * (4 - i))) & 40'hFF);
    x = 10'(by[0] + 256 * (by[1] % 4));
    y = 10'(by[2] + 256 * (by[3] % 4));
    b = 3'(by[4] % 8);
  endtask

  task automatic wait_rise(input int budget, output int at);
    int n;
    n  = 0;
    at = -1;
    while (!snd_rec && n < budget) begin
      tick();
      n++;
    end
    if (snd_rec) at = cyc;
  endtask

  task automatic serve(input logic [39:0] fr, input string nm);
    tick(); ss_in = 1'b0;
    tick(); tick();
    dout_in = fr; ss_in = 1'b1;
    tick();
    chk({nm, "_valid"}, 64'(sample_valid), 64'd1);
    tick();
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int n;
    led = v.ld; poll_now = 1'b1;
    tick();
    poll_now = 1'b0;
    n = 0;
    while (!snd_rec && n < 10) begin tick(); n++; end
    chk({nm, "_start_lat"}, 64'(n), 64'd1);
    chk({nm, "_busy"}, 64'(busy), 64'd1);
    repeat (v.lo) tick();
    ss_in = 1'b0; led = v.ld_busy;
    repeat (v.hi + 1) tick();
    chk({nm, "_sndrec_busy"}, 64'(snd_rec), 64'd1);
    dout_in = v.fr; ss_in = 1'b1;
    tick();
    chk({nm, "_valid"}, 64'(sample_valid), 64'd1);
    chk({nm, "_sndrec_latch"}, 64'(snd_rec), 64'd0);
    chk({nm, "_x"}, 64'(x_pos), 64'(v.ex));
    chk({nm, "_y"}, 64'(y_pos), 64'(v.ey));
    chk({nm, "_btn"}, 64'(btn), 64'(v.eb));
    chk({nm, "_din"}, 64'(din), 64'(v.ed));
    dout_in = ~v.fr;
    tick();
    chk({nm, "_valid_pulse"}, 64'(sample_valid), 64'd0);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_x_hold"}, 64'(x_pos), 64'(v.ex));
    last_x = v.ex; last_y = v.ey; last_b = v.eb;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at, rprev, r0, lat, nr, n;
    logic [63:0] rnd;
    vec_t v;
    bit sv_seen;

    tbl[0] = '{40'h3402780105, 2'b01, 2'b10, 1, 3, 10'h234, 10'h178, 3'b101, 8'h81};
    tbl[1] = '{40'hFFFFFFFFFF, 2'b10, 2'b10, 0, 0, 10'h3FF, 10'h3FF, 3'b111, 8'h82};
    tbl[2] = '{40'h0000000000, 2'b00, 2'b11, 2, 5, 10'h000, 10'h000, 3'b000, 8'h80};
    tbl[3] = '{40'h80FD01FEF8, 2'b11, 2'b00, 4, 1, 10'h180, 10'h201, 3'b000, 8'h83};
    tbl[4] = '{40'h7F03C30206, 2'b01, 2'b01, 0, 7, 10'h37F, 10'h2C3, 3'b110, 8'h81};

    RST = 1'b1; enable = 1'b0; poll_now = 1'b0; led = 2'b00;
    err_clr = 1'b0; ss_in = 1'b1; dout_in = '0;
    tick(); tick();
    chk("rst_snd_rec", 64'(snd_rec), 64'd0);
    chk("rst_din", 64'(din), 64'h80);
    chk("rst_data", 64'({x_pos, y_pos, btn}), 64'd0);
    chk("rst_flags", 64'({sample_valid, busy, timeout_err}), 64'd0);
    RST = 1'b0;
    repeat (3) tick();
    chk("idle_no_req", 64'(snd_rec), 64'd0);

    for (int i = 0; i < 5; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 20; i++) begin
      rnd       = {$urandom(), $urandom()};
      v.fr      = rnd[39:0];
      v.ld      = 2'($urandom_range(0, 3));
      v.ld_busy = 2'($urandom_range(0, 3));
      v.lo      = int'($urandom_range(0, 5));
      v.hi      = int'($urandom_range(0, 8));
      ref_decode(v.fr, v.ex, v.ey, v.eb);
      v.ed      = 8'(128 + int'(v.ld));
      run_txn(v, $sformatf("rnd%0d", i));
    end

    // Hang with ss_in stuck high: snd_rec high for exactly TIMEOUT cycles.
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    wait_rise(5, at);
    chk("to_rise", 64'(at >= 0), 64'd1);
    n = 0; sv_seen = 1'b0;
    while (snd_rec && n < 100) begin tick(); n++; sv_seen |= sample_valid; end
    chk("to_len", 64'(n), 64'd50);
    chk("to_err", 64'(timeout_err), 64'd1);
    chk("to_no_valid", 64'(sv_seen), 64'd0);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_data_hold", 64'({x_pos, y_pos, btn}), 64'({last_x, last_y, last_b}));
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("to_err_clr", 64'(timeout_err), 64'd0);

    // err_clr held across the abort edge: abort wins, then clears.
    err_clr = 1'b1;
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    wait_rise(5, at);
    n = 0;
    while (snd_rec && n < 100) begin tick(); n++; end
    chk("to2_len", 64'(n), 64'd50);
    chk("to2_err_wins", 64'(timeout_err), 64'd1);
    tick();
    chk("to2_err_clr", 64'(timeout_err), 64'd0);
    err_clr = 1'b0;

    // Scheduled polls every POLL_DIV cycles.
    enable = 1'b1;
    wait_rise(120, r0);
    chk("per_first", 64'(r0 >= 0), 64'd1);
    serve(40'h0102030405, "per0");
    rprev = r0;
    for (int k = 1; k < 4; k++) begin
      wait_rise(120, at);
      chk($sformatf("period%0d", k), 64'(at - rprev), 64'd100);
      serve(40'h1122334455, $sformatf("per%0d", k));
      rprev = at;
    end

    // Tick plus two poll_now pulses during BUSY coalesce into one extra transaction.
    while (cyc < rprev + 80) tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    wait_rise(5, at);
    chk("co_rise", 64'(at - rprev), 64'd82);
    ss_in = 1'b0;
    while (cyc < rprev + 100) tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0; tick();
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    dout_in = 40'h3402780105; ss_in = 1'b1;
    tick();
    chk("co_valid", 64'(sample_valid), 64'd1);
    chk("co_x", 64'(x_pos), 64'h234);
    lat = cyc;
    wait_rise(6, at);
    chk("co_extra_start", 64'(at - lat), 64'd2);
    serve(40'h0000000000, "co_extra");
    wait_rise(150, at);
    chk("co_next_sched", 64'(at - rprev), 64'd200);

    // enable drops mid-transaction: this one completes, none follow.
    tick(); ss_in = 1'b0; enable = 1'b0;
    tick(); tick();
    dout_in = 40'h5501AA0203; ss_in = 1'b1;
    tick();
    chk("en_off_valid", 64'(sample_valid), 64'd1);
    chk("en_off_xy", 64'({x_pos, y_pos, btn}), 64'({10'h155, 10'h2AA, 3'b011}));
    nr = 0;
    repeat (250) begin tick(); if (snd_rec) nr++; end
    chk("en_off_no_req", 64'(nr), 64'd0);

    // Reset held 3 cycles in BUSY.
    poll_now = 1'b1; tick(); poll_now = 1'b0;
    wait_rise(5, at);
    tick(); ss_in = 1'b0; tick(); tick();
    chk("rb_in_busy", 64'(snd_rec), 64'd1);
    RST = 1'b1; ss_in = 1'b1;
    tick(); tick(); tick();
    RST = 1'b0;
    chk("rb_snd_rec", 64'(snd_rec), 64'd0);
    chk("rb_din", 64'(din), 64'h80);
    chk("rb_data", 64'({x_pos, y_pos, btn}), 64'd0);
    chk("rb_busy", 64'(busy), 64'd0);
    nr = 0;
    repeat (5) begin tick(); if (snd_rec) nr++; end
    chk("rb_no_restart", 64'(nr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
